// File: rtl/bram_arb_ctrl_pkg.sv
// Shared definitions for the multi-channel BRAM arbiter/controller.
// - Default parameter values for the controller.
// - Read-during-write mode encodings for WRITE_FIRST.
// - Op encoding of mem_access, and an index-width helper used to size
//   the pointer and the memory address.
package bram_arb_ctrl_pkg;

  localparam int DEF_SIZE       = 1000;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_NUM_CH     = 4;

  // Data returned on a write completion's lane.
  localparam int MODE_READ_FIRST  = 0;  // lane keeps its old value
  localparam int MODE_WRITE_FIRST = 1;  // lane loads the written word

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Bits needed to index n items; at least 1 so a single item still
  // gets a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req        NUM_CH  eligible requesters
//   ptr        PTR_W   channel the search starts at (highest priority)
//   grant      NUM_CH  one-hot grant; all zero when nothing is eligible
//   grant_idx  PTR_W   index of the granted channel (0 when no grant)
module rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx
);

  int unsigned cand;
  logic        found;

  // Walk the channels ptr, ptr+1, ... (wrapping) and take the first one
  // requesting.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = (int'(ptr) + k) % NUM_CH;
      if (!found && req[PTR_W'(cand)]) begin
        grant[PTR_W'(cand)] = 1'b1;
        grant_idx           = PTR_W'(cand);
        found               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_arb_ctrl.sv
// Round-robin arbitrated single-port BRAM controller.
// NUM_CH requesters share one SIZE-word memory; each channel uses a
// level req held until its one-cycle done pulse.
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-high reset
//   mem_req       per-channel request (level)
//   mem_access    per-channel op, 1 = write, 0 = read
//   mem_addr_in   flattened addresses, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   mem_data_in   flattened write data, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mem_data_out  flattened per-channel read data
//   mem_done      one-cycle completion pulse per channel
//   mem_err       pulses with mem_done when the address was >= SIZE
//   busy          high in any cycle a grant is issued
module bram_arb_ctrl
  import bram_arb_ctrl_pkg::*;
#(
  parameter int SIZE        = DEF_SIZE,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int WRITE_FIRST = MODE_READ_FIRST
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            mem_req,
  input  logic [NUM_CH-1:0]            mem_access,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] mem_addr_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] mem_data_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] mem_data_out,
  output logic [NUM_CH-1:0]            mem_done,
  output logic [NUM_CH-1:0]            mem_err,
  output logic                         busy
);

  localparam int PTR_W  = idx_width(NUM_CH);
  localparam int MEM_AW = idx_width(SIZE);
  localparam logic [ADDR_WIDTH:0] SIZE_X = (ADDR_WIDTH + 1)'(SIZE);

  logic [DATA_WIDTH-1:0] bram [SIZE];

  logic [PTR_W-1:0]      ptr;
  logic [NUM_CH-1:0]     eligible;
  logic [NUM_CH-1:0]     grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  logic                  g_write;
  logic                  in_range;
  logic [MEM_AW-1:0]     mem_idx;
  logic [PTR_W-1:0]      ptr_next;

  // A channel is masked during its own done cycle so a requester that is
  // still dropping req is not granted a second time.
  assign eligible = mem_req & ~mem_done;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign grant_valid = |grant;
  // A grant in a reset cycle is discarded, so it is not reported as busy.
  assign busy        = grant_valid & ~reset;

  assign g_addr   = mem_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_wdata  = mem_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign g_write  = (op_e'(mem_access[grant_idx]) == OP_WRITE);
  assign in_range = ({1'b0, g_addr} < SIZE_X);
  assign mem_idx  = g_addr[MEM_AW-1:0];
  assign ptr_next = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: the memory array has no reset branch; clearing it would turn the
  // BRAM into a register file, and its contents must survive reset anyway.
  always_ff @(posedge clk) begin
    if (!reset && grant_valid && g_write && in_range) begin
      bram[mem_idx] <= g_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr          <= '0;
      mem_done     <= '0;
      mem_err      <= '0;
      mem_data_out <= '0;
    end else begin
      mem_done <= grant;
      mem_err  <= in_range ? '0 : grant;
      if (grant_valid) begin
        ptr <= ptr_next;
        if (!g_write) begin
          mem_data_out[grant_idx*DATA_WIDTH +: DATA_WIDTH] <=
            in_range ? bram[mem_idx] : '0;
        end else if (WRITE_FIRST == MODE_WRITE_FIRST && in_range) begin
          mem_data_out[grant_idx*DATA_WIDTH +: DATA_WIDTH] <= g_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_arb_ctrl.sv
// Directed bench for bram_arb_ctrl: SIZE=11, DATA_WIDTH=3, ADDR_WIDTH=4,
// NUM_CH=2. Two instances share the stimulus, one per read-during-write
// mode, so the mode-dependent lane behaviour is checked side by side.
module tb_bram_arb_ctrl;

  localparam int SIZE = 11;
  localparam int DW   = 3;
  localparam int AW   = 4;
  localparam int NCH  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  req;
  logic [NCH-1:0]  acc;
  logic [NCH*AW-1:0] addr;
  logic [NCH*DW-1:0] wdata;
  logic [NCH*DW-1:0] data_rf, data_wf;
  logic [NCH-1:0]  done_rf, done_wf, err_rf, err_wf;
  logic            busy_rf, busy_wf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bram_arb_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH),
                  .WRITE_FIRST(0)) dut_rf (
    .clk(clk), .reset(reset), .mem_req(req), .mem_access(acc),
    .mem_addr_in(addr), .mem_data_in(wdata), .mem_data_out(data_rf),
    .mem_done(done_rf), .mem_err(err_rf), .busy(busy_rf));

  bram_arb_ctrl #(.SIZE(SIZE), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NCH),
                  .WRITE_FIRST(1)) dut_wf (
    .clk(clk), .reset(reset), .mem_req(req), .mem_access(acc),
    .mem_addr_in(addr), .mem_data_in(wdata), .mem_data_out(data_wf),
    .mem_done(done_wf), .mem_err(err_wf), .busy(busy_wf));

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete transaction on one channel: raise req, observe busy in the
  // grant cycle, observe done/err/lanes one cycle later, drop req, then
  // observe that done was a single-cycle pulse.
  task automatic single_op(input int ch, input logic wr, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic b, output logic dn,
                           output logic er, output logic dn_after,
                           output logic [DW-1:0] l_rf, output logic [DW-1:0] l_wf);
    @(posedge clk); #1;
    req[ch] = 1'b1; acc[ch] = wr;
    addr[ch*AW +: AW] = a; wdata[ch*DW +: DW] = d;
    @(negedge clk);
    b = busy_rf;
    @(negedge clk);
    dn = done_rf[ch]; er = err_rf[ch];
    l_rf = data_rf[ch*DW +: DW]; l_wf = data_wf[ch*DW +: DW];
    @(posedge clk); #1;
    req[ch] = 1'b0;
    @(negedge clk);
    dn_after = done_rf[ch];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    checks++; if (done_rf !== 2'b00 || done_wf !== 2'b00) begin failures++; $display("FAIL reset_done got=%b/%b exp=00", done_rf, done_wf); end
    checks++; if (err_rf !== 2'b00 || err_wf !== 2'b00) begin failures++; $display("FAIL reset_err got=%b/%b exp=00", err_rf, err_wf); end
    checks++; if (busy_rf !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_rf); end
    checks++; if (data_rf !== '0 || data_wf !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", data_rf, data_wf); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic b, dn, er, dna;
    logic [DW-1:0] lr, lw;
    single_op(0, 1'b1, 4'd3, 3'd5, b, dn, er, dna, lr, lw);
    checks++; if (b !== 1'b1) begin failures++; $display("FAIL single_wr_busy got=%b exp=1", b); end
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL single_wr_done got=%b exp=1", dn); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL single_wr_err got=%b exp=0", er); end
    checks++; if (dna !== 1'b0) begin failures++; $display("FAIL single_wr_done_width got=%b exp=0", dna); end
    single_op(0, 1'b0, 4'd3, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (dn !== 1'b1) begin failures++; $display("FAIL single_rd_done got=%b exp=1", dn); end
    checks++; if (lr !== 3'd5 || lw !== 3'd5) begin failures++; $display("FAIL single_rd_data got=%0d/%0d exp=5", lr, lw); end
  endtask

  task automatic test_contention();
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    // Both channels raise req in the same cycle: ch0 writes 1 @0, ch1 writes 2 @1.
    @(posedge clk); #1;
    req = 2'b11; acc = 2'b11;
    addr = {4'd1, 4'd0}; wdata = {3'd2, 3'd1};
    @(negedge clk);
    checks++; if (busy_rf !== 1'b1 || done_rf !== 2'b00) begin failures++; $display("FAIL cont_t0 got busy=%b done=%b exp busy=1 done=00", busy_rf, done_rf); end
    @(negedge clk);
    checks++; if (done_rf !== 2'b01) begin failures++; $display("FAIL cont_t1_done got=%b exp=01", done_rf); end
    @(posedge clk); #1; req[0] = 1'b0;
    @(negedge clk);
    checks++; if (done_rf !== 2'b10) begin failures++; $display("FAIL cont_t2_done got=%b exp=10", done_rf); end
    @(posedge clk); #1; req[1] = 1'b0;
    @(negedge clk);
    checks++; if (done_rf !== 2'b00) begin failures++; $display("FAIL cont_t3_done got=%b exp=00", done_rf); end
  endtask

  // Pointer is back at 0 after the contention test, so ch0 goes first.
  task automatic test_back_to_back();
    logic [NCH-1:0] exp_done;
    @(posedge clk); #1;
    req = 2'b11; acc = 2'b00;
    addr = {4'd0, 4'd3};
    @(negedge clk);
    checks++; if (done_rf !== 2'b00) begin failures++; $display("FAIL b2b_t0_done got=%b exp=00", done_rf); end
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 8) req = 2'b00;
      @(negedge clk);
      exp_done = (k % 2 == 1) ? 2'b01 : 2'b10;
      checks++; if (done_rf !== exp_done) begin failures++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", k, done_rf, exp_done); end
      if (k % 2 == 1) begin
        checks++; if (data_rf[0 +: DW] !== 3'd5) begin failures++; $display("FAIL b2b_lane0 cycle=%0d got=%0d exp=5", k, data_rf[0 +: DW]); end
      end else begin
        checks++; if (data_rf[DW +: DW] !== 3'd1) begin failures++; $display("FAIL b2b_lane1 cycle=%0d got=%0d exp=1", k, data_rf[DW +: DW]); end
      end
    end
    @(negedge clk);
    checks++; if (done_rf !== 2'b00) begin failures++; $display("FAIL b2b_tail_done got=%b exp=00", done_rf); end
  endtask

  task automatic test_out_of_range();
    logic b, dn, er, dna;
    logic [DW-1:0] lr, lw;
    single_op(1, 1'b1, 4'd12, 3'd7, b, dn, er, dna, lr, lw);
    checks++; if (dn !== 1'b1 || er !== 1'b1) begin failures++; $display("FAIL oor_wr12 got done=%b err=%b exp 1/1", dn, er); end
    single_op(1, 1'b0, 4'd12, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (dn !== 1'b1 || er !== 1'b1) begin failures++; $display("FAIL oor_rd12 got done=%b err=%b exp 1/1", dn, er); end
    checks++; if (lr !== 3'd0 || lw !== 3'd0) begin failures++; $display("FAIL oor_rd12_data got=%0d/%0d exp=0", lr, lw); end
    single_op(1, 1'b1, 4'd11, 3'd7, b, dn, er, dna, lr, lw);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL oor_wr11_err got=%b exp=1", er); end
    single_op(1, 1'b1, 4'd10, 3'd4, b, dn, er, dna, lr, lw);
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL last_wr10_err got=%b exp=0", er); end
    single_op(1, 1'b0, 4'd10, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (lr !== 3'd4 || er !== 1'b0) begin failures++; $display("FAIL last_rd10 got data=%0d err=%b exp 4/0", lr, er); end
    single_op(0, 1'b0, 4'd3, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (lr !== 3'd5 || er !== 1'b0) begin failures++; $display("FAIL oor_keep3 got data=%0d err=%b exp 5/0", lr, er); end
  endtask

  task automatic test_mode();
    logic b, dn, er, dna;
    logic [DW-1:0] lr, lw;
    single_op(0, 1'b1, 4'd3, 3'd6, b, dn, er, dna, lr, lw);
    checks++; if (lr !== 3'd5) begin failures++; $display("FAIL mode_rf_lane got=%0d exp=5", lr); end
    checks++; if (lw !== 3'd6) begin failures++; $display("FAIL mode_wf_lane got=%0d exp=6", lw); end
    single_op(0, 1'b0, 4'd3, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (lr !== 3'd6 || lw !== 3'd6) begin failures++; $display("FAIL mode_readback got=%0d/%0d exp=6", lr, lw); end
  endtask

  task automatic test_reset_mid_op();
    logic b, dn, er, dna;
    logic [DW-1:0] lr, lw;
    single_op(0, 1'b1, 4'd4, 3'd3, b, dn, er, dna, lr, lw);
    @(posedge clk); #1;
    req[0] = 1'b1; acc[0] = 1'b1; addr[0 +: AW] = 4'd4; wdata[0 +: DW] = 3'd2;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req[0] = 1'b0;
    @(negedge clk);
    checks++; if (done_rf !== 2'b00 || done_wf !== 2'b00) begin failures++; $display("FAIL rmid_done got=%b/%b exp=00", done_rf, done_wf); end
    checks++; if (err_rf !== 2'b00 || busy_rf !== 1'b0) begin failures++; $display("FAIL rmid_err_busy got=%b/%b exp=00/0", err_rf, busy_rf); end
    checks++; if (data_rf !== '0 || data_wf !== '0) begin failures++; $display("FAIL rmid_data got=%h/%h exp=0", data_rf, data_wf); end
    @(negedge clk);
    checks++; if (done_rf !== 2'b00) begin failures++; $display("FAIL rmid_done_late got=%b exp=00", done_rf); end
    single_op(0, 1'b0, 4'd4, 3'd0, b, dn, er, dna, lr, lw);
    checks++; if (lr !== 3'd3 || lw !== 3'd3) begin failures++; $display("FAIL rmid_readback got=%0d/%0d exp=3", lr, lw); end
  endtask

  initial begin
    reset = 1'b1;
    req   = '0;
    acc   = '0;
    addr  = '0;
    wdata = '0;
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_out_of_range();
    test_mode();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
